// File: rtl/jk_ubus_slave_responder.sv
// UBUS slave responder: byte-wide backing memory, programmable wait states,
// out-of-range error per beat and sticky bip/read-write protocol checking.
module jk_ubus_slave_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [1:0]  size,
    input  logic        read,
    input  logic        write,
    input  logic        bip,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        wait_state,
    output logic        error,
    output logic        protocol_err
);

    localparam int unsigned AW        = $clog2(MEM_DEPTH);
    localparam logic [16:0] LO_ADDR   = 17'(BASE_ADDR);
    localparam logic [16:0] DEPTH     = 17'(MEM_DEPTH);
    localparam bit          HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [2:0]  WAIT_LOAD = HAS_WAIT ? 3'(WAIT_CYCLES - 1) : 3'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]  state,    state_nxt;
    logic [2:0]  wait_cnt, wait_cnt_nxt;
    logic [2:0]  idx,      idx_nxt;
    logic [2:0]  last_idx, last_idx_nxt;
    logic [15:0] lat_addr, lat_addr_nxt;
    logic        lat_rd,   lat_rd_nxt;
    logic        perr_set;

    logic [7:0]  mem [MEM_DEPTH];

    // Address decode for the beat in progress (write path)
    logic [15:0] cur_ba;
    logic [16:0] cur_off;
    logic        cur_in;
    logic [AW-1:0] cur_mi;

    // Address decode for the beat about to start (read prefetch and output regs)
    logic [15:0] nxt_ba;
    logic [16:0] nxt_off;
    logic        nxt_in;
    logic [AW-1:0] nxt_mi;

    logic mem_we;

    always_comb begin
        cur_ba  = lat_addr + 16'(idx);
        cur_off = {1'b0, cur_ba} - LO_ADDR;
        cur_in  = (cur_off < DEPTH);
        cur_mi  = AW'(cur_off);

        nxt_ba  = lat_addr_nxt + 16'(idx_nxt);
        nxt_off = {1'b0, nxt_ba} - LO_ADDR;
        nxt_in  = (nxt_off < DEPTH);
        nxt_mi  = AW'(nxt_off);

        mem_we  = (state == S_DATA) && !lat_rd && cur_in && !reset;
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        idx_nxt      = idx;
        last_idx_nxt = last_idx;
        lat_addr_nxt = lat_addr;
        lat_rd_nxt   = lat_rd;
        perr_set     = 1'b0;

        case (state)
            S_IDLE: begin
                if (read ^ write) begin
                    lat_addr_nxt = addr;
                    lat_rd_nxt   = read;
                    last_idx_nxt = 3'((4'd1 << size) - 4'd1);
                    idx_nxt      = 3'd0;
                    wait_cnt_nxt = WAIT_LOAD;
                    state_nxt    = HAS_WAIT ? S_WAIT : S_DATA;
                end else if (read && write) begin
                    perr_set = 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_nxt = S_DATA;
                end else begin
                    wait_cnt_nxt = wait_cnt - 3'd1;
                end
            end
            S_DATA: begin
                perr_set = (bip != (idx != last_idx));
                if (idx == last_idx) begin
                    state_nxt = S_IDLE;
                end else begin
                    idx_nxt      = idx + 3'd1;
                    wait_cnt_nxt = WAIT_LOAD;
                    state_nxt    = HAS_WAIT ? S_WAIT : S_DATA;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
            idx      <= 3'd0;
            last_idx <= 3'd0;
            lat_addr <= 16'h0000;
            lat_rd   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            idx      <= idx_nxt;
            last_idx <= last_idx_nxt;
            lat_addr <= lat_addr_nxt;
            lat_rd   <= lat_rd_nxt;
        end
    end

    // Backing store is deliberately left uninitialised across reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_mi] <= data_in;
        end
    end

    // Outputs are registered from the upcoming state so they line up with the beat cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out     <= 8'h00;
            data_oe      <= 1'b0;
            wait_state   <= 1'b0;
            error        <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            wait_state <= (state_nxt == S_WAIT);
            data_oe    <= (state_nxt == S_DATA) && lat_rd_nxt;
            error      <= (state_nxt == S_DATA) && !nxt_in;
            data_out   <= ((state_nxt == S_DATA) && lat_rd_nxt && nxt_in) ? mem[nxt_mi] : 8'h00;
            if (perr_set) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jk_ubus_slave_responder.sv
// Directed bench for jk_ubus_slave_responder: three instances with different
// base/wait settings, each driven through its own set of bus signals.
module tb_jk_ubus_slave_responder;

    logic        clk;
    logic        rst_v  [3];
    logic [15:0] addr_v [3];
    logic [1:0]  size_v [3];
    logic        rd_v   [3];
    logic        wr_v   [3];
    logic        bip_v  [3];
    logic [7:0]  din_v  [3];
    logic [7:0]  dout_v [3];
    logic        oe_v   [3];
    logic        ws_v   [3];
    logic        err_v  [3];
    logic        perr_v [3];

    int n_pass;
    int n_total;

    // Instance 0: base 0 no waits; 1: base 0 two waits; 2: base 0x1000 no waits
    for (genvar g = 0; g < 3; g++) begin : g_dut
        jk_ubus_slave_responder #(
            .BASE_ADDR  ((g == 2) ? 16'h1000 : 16'h0000),
            .MEM_DEPTH  (256),
            .WAIT_CYCLES((g == 1) ? 2 : 0)
        ) u_dut (
            .clk         (clk),
            .reset       (rst_v[g]),
            .addr        (addr_v[g]),
            .size        (size_v[g]),
            .read        (rd_v[g]),
            .write       (wr_v[g]),
            .bip         (bip_v[g]),
            .data_in     (din_v[g]),
            .data_out    (dout_v[g]),
            .data_oe     (oe_v[g]),
            .wait_state  (ws_v[g]),
            .error       (err_v[g]),
            .protocol_err(perr_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transfer on instance s; called at a negedge, returns at the negedge after the last beat
    task automatic xfer(input int s, input bit rd, input logic [15:0] a, input logic [1:0] sz,
                        input logic [63:0] wd, input logic [7:0] bm,
                        input logic [63:0] xd, input logic [7:0] em, input string nm);
        int nb;
        int w;
        nb = 1 << sz;
        w  = (s == 1) ? 2 : 0;
        addr_v[s] = a;
        size_v[s] = sz;
        rd_v[s]   = rd;
        wr_v[s]   = !rd;
        @(negedge clk);
        rd_v[s] = 1'b0;
        wr_v[s] = 1'b0;
        for (int k = 0; k < nb; k++) begin
            bip_v[s] = bm[k];
            din_v[s] = wd[8*k +: 8];
            for (int i = 0; i < w; i++) begin
                check($sformatf("%s ws b%0d c%0d", nm, k, i), 32'(ws_v[s]), 32'd1);
                check($sformatf("%s oe_in_wait b%0d", nm, k), 32'(oe_v[s]), 32'd0);
                @(negedge clk);
            end
            check($sformatf("%s ws_beat b%0d", nm, k), 32'(ws_v[s]), 32'd0);
            check($sformatf("%s oe b%0d", nm, k), 32'(oe_v[s]), 32'(rd));
            check($sformatf("%s err b%0d", nm, k), 32'(err_v[s]), 32'(em[k]));
            if (rd) begin
                check($sformatf("%s data b%0d", nm, k), 32'(dout_v[s]), 32'(xd[8*k +: 8]));
            end
            @(negedge clk);
        end
        bip_v[s] = 1'b0;
        check($sformatf("%s idle_ws", nm), 32'(ws_v[s]), 32'd0);
        check($sformatf("%s idle_oe", nm), 32'(oe_v[s]), 32'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 3; i++) begin
            rst_v[i]  = 1'b1;
            addr_v[i] = 16'h0000;
            size_v[i] = 2'd0;
            rd_v[i]   = 1'b0;
            wr_v[i]   = 1'b0;
            bip_v[i]  = 1'b0;
            din_v[i]  = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst dout u%0d", i), 32'(dout_v[i]), 32'd0);
            check($sformatf("rst oe u%0d", i),   32'(oe_v[i]),   32'd0);
            check($sformatf("rst ws u%0d", i),   32'(ws_v[i]),   32'd0);
            check($sformatf("rst err u%0d", i),  32'(err_v[i]),  32'd0);
            check($sformatf("rst perr u%0d", i), 32'(perr_v[i]), 32'd0);
            rst_v[i] = 1'b0;
        end

        // Single byte write then back-to-back read, no waits
        xfer(0, 1'b0, 16'h0010, 2'd0, 64'hA5, 8'h00, 64'h0, 8'h00, "wr1");
        xfer(0, 1'b1, 16'h0010, 2'd0, 64'h0,  8'h00, 64'hA5, 8'h00, "rd1");
        check("rd1 perr", 32'(perr_v[0]), 32'd0);

        // Four-byte burst with two wait states per beat
        xfer(1, 1'b0, 16'h0020, 2'd2, 64'h44332211, 8'h07, 64'h0, 8'h00, "wrw");
        xfer(1, 1'b1, 16'h0020, 2'd2, 64'h0, 8'h07, 64'h44332211, 8'h00, "rdw");
        check("rdw perr", 32'(perr_v[1]), 32'd0);

        // Range edge at base 0x1000: last two bytes in range, next two beyond
        xfer(2, 1'b0, 16'h10FE, 2'd1, 64'hC35A, 8'h01, 64'h0, 8'h00, "wredge");
        xfer(2, 1'b1, 16'h10FE, 2'd2, 64'h0, 8'h07, 64'h0000C35A, 8'h0C, "rdedge");
        xfer(2, 1'b0, 16'h1000, 2'd0, 64'h3C, 8'h00, 64'h0, 8'h00, "wrbase");
        xfer(2, 1'b0, 16'h2000, 2'd0, 64'h77, 8'h00, 64'h0, 8'h01, "wroor");
        xfer(2, 1'b1, 16'h1000, 2'd0, 64'h0, 8'h00, 64'h3C, 8'h00, "rdbase");
        xfer(2, 1'b1, 16'h0FFF, 2'd0, 64'h0, 8'h00, 64'h00, 8'h01, "rdbelow");
        check("oor perr", 32'(perr_v[2]), 32'd0);

        // bip dropped early on beat 1: sticky protocol error, all bytes still written
        xfer(1, 1'b0, 16'h0030, 2'd2, 64'h04030201, 8'h05, 64'h0, 8'h00, "wrbip");
        check("bip perr set", 32'(perr_v[1]), 32'd1);
        xfer(1, 1'b1, 16'h0030, 2'd2, 64'h0, 8'h07, 64'h04030201, 8'h00, "rdbip");
        check("bip perr sticky", 32'(perr_v[1]), 32'd1);

        // read and write together: no transfer, protocol error, memory untouched
        addr_v[0] = 16'h0010;
        size_v[0] = 2'd0;
        din_v[0]  = 8'hEE;
        rd_v[0]   = 1'b1;
        wr_v[0]   = 1'b1;
        @(negedge clk);
        rd_v[0] = 1'b0;
        wr_v[0] = 1'b0;
        check("rw perr", 32'(perr_v[0]), 32'd1);
        check("rw oe", 32'(oe_v[0]), 32'd0);
        check("rw ws", 32'(ws_v[0]), 32'd0);
        @(negedge clk);
        check("rw oe2", 32'(oe_v[0]), 32'd0);
        xfer(0, 1'b1, 16'h0010, 2'd0, 64'h0, 8'h00, 64'hA5, 8'h00, "rw_rd");

        // Reset during beat 3 of an eight-byte write
        xfer(0, 1'b0, 16'h0040, 2'd3, 64'hF7F6F5F4F3F2F1F0, 8'h7F, 64'h0, 8'h00, "prefill");
        addr_v[0] = 16'h0040;
        size_v[0] = 2'd3;
        wr_v[0]   = 1'b1;
        @(negedge clk);
        wr_v[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            din_v[0] = 8'(k);
            bip_v[0] = 1'b1;
            check($sformatf("abort ws b%0d", k), 32'(ws_v[0]), 32'd0);
            check($sformatf("abort err b%0d", k), 32'(err_v[0]), 32'd0);
            @(negedge clk);
        end
        din_v[0] = 8'h03;
        rst_v[0] = 1'b1;
        @(negedge clk);
        check("abort dout", 32'(dout_v[0]), 32'd0);
        check("abort oe",   32'(oe_v[0]),   32'd0);
        check("abort ws",   32'(ws_v[0]),   32'd0);
        check("abort err",  32'(err_v[0]),  32'd0);
        check("abort perr", 32'(perr_v[0]), 32'd0);
        rst_v[0] = 1'b0;
        bip_v[0] = 1'b0;
        xfer(0, 1'b1, 16'h0040, 2'd3, 64'h0, 8'h7F, 64'hF7F6F5F4F3020100, 8'h00, "postrst");
        check("postrst perr", 32'(perr_v[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jk_ubus_slave_responder.md
Name: jk_ubus_slave_responder

Overview:
UBUS slave-side responder with a byte-wide memory. It sits on the slave end of the UBUS interface and answers master transfers: it captures the address phase, inserts programmable wait states, and stores write data or returns read data one byte per data beat. It flags out-of-range accesses with error and checks the master's bip sequencing. Used as the responding endpoint in VIP testbenches in place of a real peripheral.

Parameters:
BASE_ADDR, 16'h0000, first byte address decoded by this slave
MEM_DEPTH, 256, number of bytes of backing memory (power of 2, 16..4096)
WAIT_CYCLES, 0, wait-state cycles inserted before every data beat (0..7)

Ports:
clk  input  1  bus clock
reset  input  1  synchronous active-high reset
addr  input  16  transfer start address, valid in address phase
size  input  2  transfer length code: 0=1, 1=2, 2=4, 3=8 bytes
read  input  1  address-phase read request
write  input  1  address-phase write request
bip  input  1  burst in progress; master drives 1 on every data beat except the last
data_in  input  8  write data from master
data_out  output  8  read data to master
data_oe  output  1  data_out valid/drive enable (read beat only)
wait_state  output  1  1 = current data-phase cycle is a wait, beat not taken
error  output  1  1 = current data beat failed (out of range)
protocol_err  output  1  sticky: bip mismatch or read&write together seen

Behaviour:
- Reset (sync, active-high): state IDLE; data_out=0, data_oe=0, wait_state=0, error=0, protocol_err=0; beat counter=0. Memory contents are NOT cleared. Reset mid-transfer aborts immediately, with no further memory writes.
- States: IDLE, WAIT, DATA.
- IDLE: on a cycle with exactly one of read/write = 1, latch addr, size, and direction; beats = 1<<size; idx = 0. Next state is WAIT if WAIT_CYCLES>0, else DATA. read&write both 1: no transfer, set protocol_err, stay IDLE.
- WAIT: wait_state=1, data_oe=0, error=0. Stays for exactly WAIT_CYCLES cycles (down counter), then DATA.
- DATA (one beat, one cycle): wait_state=0. Byte address ba = latched_addr + idx, computed in 16 bits (wraps at 16'hFFFF).
  - In range when BASE_ADDR <= ba < BASE_ADDR+MEM_DEPTH. Memory index = ba - BASE_ADDR.
  - Write beat: mem[index] <= data_in at the end of the cycle if in range. Out of range: no write, error=1.
  - Read beat: data_oe=1; data_out=mem[index] if in range, else 8'h00 with error=1.
  - bip check: expected bip = (idx != beats-1). Any mismatch sets protocol_err; the transfer continues regardless.
  - After the beat, idx++. If idx reaches beats, go to IDLE; else go to WAIT (WAIT_CYCLES>0) or DATA.
- Timing:
  - Address phase in cycle N.
  - First beat in cycle N+1+WAIT_CYCLES.
  - Beat k in cycle N+1+k*(WAIT_CYCLES+1)+WAIT_CYCLES.
  - Total data phase = beats*(WAIT_CYCLES+1) cycles.
- Outputs are combinational decode of registered state/counters and a registered memory read (read data is prefetched during the preceding WAIT/DATA/IDLE cycle so it is valid in the beat cycle). No input-to-output combinational path except via memory index registers.
- read/write asserted while not IDLE: ignored; UBUS forbids this, so it is not checked.
- Back-to-back: a new address phase is accepted in the cycle immediately after the last beat (state is IDLE).
- error is per-beat only, not sticky. protocol_err is cleared only by reset.

Test Plan:
- Single write then read: BASE=0, WAIT=0. Write addr 16'h0010 size 0 data 8'hA5, bip=0. Then read 16'h0010 size 0 -> read beat one cycle after the address phase, data_oe=1, data_out=8'hA5, wait_state=0, error=0.
- Burst with waits: WAIT=2. Write 16'h0020 size 2 with bytes 11,22,33,44, bip 1,1,1,0 -> each beat preceded by 2 wait_state=1 cycles, 12 data-phase cycles total. Read back -> 11,22,33,44 on beats, protocol_err=0.
- Out of range: BASE=16'h1000, DEPTH=256. Read 16'h10FE size 2 -> beats 0,1 error=0; beats 2,3 error=1 with data_out=0. A write to 16'h2000 leaves memory unchanged.
- bip violation: 4-byte write with bip=0 on beat 1 -> protocol_err rises after that beat and stays 1. All 4 bytes are still written.
- Reset mid-burst: start an 8-byte write, assert reset during beat 3 -> next cycle state is IDLE and all outputs are 0. Readback shows bytes 0-2 written and bytes 3-7 unchanged; a new transfer issued immediately afterwards completes correctly.
- read&write together in the address phase -> no beats, protocol_err=1, memory unchanged.
